// File: rtl/seq_match_pkg.sv
// Shared types and default sizes for the serial pattern-match run controller.
package seq_match_pkg;

   localparam int PAT_W_DEF = 3;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_e;

endpackage

// File: rtl/seq_match_hist.sv
// Serial history shift register, fill counter and pattern comparator.
// SEQ_MATCH_OVERLAP_EN keeps history after a match; otherwise it clears on the matching edge.
module seq_match_hist
   import seq_match_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             clr,
   input  logic [PAT_W-1:0] pattern,
   input  logic             x,
   output logic             hit
);

   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q, hist_d, hist_nxt;
   logic [FILL_W-1:0] fill_q, fill_d, fill_nxt;

   always_comb begin
      hist_nxt = hist_q;
      fill_nxt = fill_q;
      if (shift_en) begin
         hist_nxt = {hist_q[PAT_W-2:0], x};
         if (fill_q != FILL_FULL) fill_nxt = fill_q + FILL_W'(1);
      end
      // hit looks at the post-shift window so the match registers on the completing edge
      hit    = shift_en && (fill_nxt == FILL_FULL) && (hist_nxt == pattern);
      hist_d = hist_nxt;
      fill_d = fill_nxt;
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end
`ifndef SEQ_MATCH_OVERLAP_EN
      else if (hit) begin
         hist_d = '0;
         fill_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller: arms on start, counts pattern matches until target or sample budget, sticky done.
// Overlapping-match counting is selected by SEQ_MATCH_OVERLAP_EN (see seq_match_hist).
module seq_match_ctrl
   import seq_match_pkg::*;
#(
   parameter int               PAT_W       = PAT_W_DEF,
   parameter int               CNT_W       = CNT_W_DEF,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 3'b101
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             start,
   input  logic             abort,
   input  logic             ack,
   input  logic [CNT_W-1:0] target_cnt,
   input  logic [CNT_W-1:0] max_samples,
   input  logic             x_valid,
   input  logic             x,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done,
   output logic             timed_out,
   output state_e           dbg_state
);

   // x is consumed only on edges where x_valid=1 while ARMED; there is no back-pressure.
   state_e           state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] samp_q, samp_d, samp_inc;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d, cnt_inc;
   logic             match_q, match_d;
   logic             hist_clr, shift_en, hit;

   assign shift_en = (state_q == ARMED) && x_valid;

   seq_match_hist #(.PAT_W(PAT_W)) u_hist (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .clr      (hist_clr),
      .pattern  (pattern_q),
      .x        (x),
      .hit      (hit)
   );

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      target_d    = target_q;
      max_d       = max_q;
      samp_d      = samp_q;
      match_cnt_d = match_cnt_q;
      match_d     = 1'b0;
      hist_clr    = 1'b0;
      samp_inc    = (&samp_q) ? samp_q : samp_q + CNT_W'(1);
      cnt_inc     = (&match_cnt_q) ? match_cnt_q : match_cnt_q + CNT_W'(1);
      case (state_q)
         IDLE: begin
            if (cfg_we) pattern_d = cfg_pattern;
            if (start) begin
               target_d    = target_cnt;
               max_d       = max_samples;
               samp_d      = '0;
               match_cnt_d = '0;
               hist_clr    = 1'b1;
               state_d     = ARMED;
            end
         end
         ARMED: begin
            if (abort) begin
               state_d = IDLE;
            end else if (target_q == '0) begin
               state_d = DONE;
            end else if (x_valid) begin
               samp_d = samp_inc;
               if (hit) begin
                  match_d     = 1'b1;
                  match_cnt_d = cnt_inc;
               end
               // reaching the target on the last budgeted sample still counts as DONE
               if (hit && (cnt_inc == target_q))                 state_d = DONE;
               else if ((max_q != '0) && (samp_inc == max_q))    state_d = TIMEOUT;
            end
         end
         DONE, TIMEOUT: begin
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pattern_q   <= PAT_DEFAULT;
         target_q    <= '0;
         max_q       <= '0;
         samp_q      <= '0;
         match_cnt_q <= '0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         target_q    <= target_d;
         max_q       <= max_d;
         samp_q      <= samp_d;
         match_cnt_q <= match_cnt_d;
         match_q     <= match_d;
      end
   end

   assign busy      = (state_q == ARMED);
   assign done      = (state_q == DONE) || (state_q == TIMEOUT);
   assign timed_out = (state_q == TIMEOUT);
   assign match     = match_q;
   assign match_cnt = match_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl against a queue-based model of the match rules.
module tb_seq_match_ctrl;
  import seq_match_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cfg_we, start, abort, ack, x_valid, x;
  logic [2:0] cfg_pattern;
  logic [7:0] target_cnt, max_samples;
  logic       busy, match, done, timed_out;
  logic [7:0] match_cnt;
  state_e     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_MATCH_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  // clock/reset block
  always #5 clk = ~clk;

  seq_match_ctrl #(.PAT_W(3), .CNT_W(8), .PAT_DEFAULT(3'b101)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .start       (start),
    .abort       (abort),
    .ack         (ack),
    .target_cnt  (target_cnt),
    .max_samples (max_samples),
    .x_valid     (x_valid),
    .x           (x),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .timed_out   (timed_out),
    .dbg_state   (dbg_state)
  );

  // reference model: 0 idle, 1 armed, 2 done, 3 timeout; history as a queue of sampled bits
  int         m_st, m_cnt, m_samp, m_tgt, m_max;
  bit         m_hist[$];
  logic [2:0] m_pat;
  bit         m_match;

  task automatic mdl_reset();
    m_st = 0; m_cnt = 0; m_samp = 0; m_tgt = 0; m_max = 0;
    m_hist.delete(); m_pat = 3'b101; m_match = 1'b0;
  endtask

  task automatic mdl_edge(input bit v, input bit b, input bit ab, input bit ak,
                          input bit st, input bit cw, input logic [2:0] cp, input int t, input int mx);
    bit hit;
    m_match = 1'b0;
    case (m_st)
      0: begin
        if (cw) m_pat = cp;
        if (st) begin
          m_tgt = t; m_max = mx; m_cnt = 0; m_samp = 0; m_hist.delete(); m_st = 1;
        end
      end
      1: begin
        if (ab) m_st = 0;
        else if (m_tgt == 0) m_st = 2;
        else if (v) begin
          m_hist.push_back(b);
          if (m_hist.size() > 3) void'(m_hist.pop_front());
          m_samp++;
          hit = (m_hist.size() == 3) && (m_hist[0] == m_pat[2]) &&
                (m_hist[1] == m_pat[1]) && (m_hist[2] == m_pat[0]);
          if (hit) begin
            m_match = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (!OVL) m_hist.delete();
          end
          if (hit && m_cnt == m_tgt) m_st = 2;
          else if (m_max != 0 && m_samp == m_max) m_st = 3;
        end
      end
      default: if (ak) m_st = 0;
    endcase
  endtask

  // driver: apply one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input bit v, input bit b, input bit ab, input bit ak,
                      input bit st, input bit cw, input logic [2:0] cp, input int t, input int mx);
    x_valid = v; x = b; abort = ab; ack = ak; start = st; cfg_we = cw;
    cfg_pattern = cp; target_cnt = 8'(t); max_samples = 8'(mx);
    mdl_edge(v, b, ab, ak, st, cw, cp, t, mx);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input string nm, input bit cw, input logic [2:0] cp, input int t,
                            input int mx, input string bits, input int gap, input int abort_at);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw, cp, t, mx);
    n_tests++;
    if (match !== m_match || match_cnt !== 8'(m_cnt) || busy !== (m_st == 1)) begin
      n_fail++;
      $display("FAIL %s arm: match=%b cnt=%0d busy=%b, expected match=%b cnt=%0d busy=%b",
               nm, match, match_cnt, busy, m_match, m_cnt, (m_st == 1));
    end
    for (int i = 0; i < bits.len(); i++) begin
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), 0, 0);
        n_tests++;
        if (match !== m_match || match_cnt !== 8'(m_cnt)) begin
          n_fail++;
          $display("FAIL %s gap%0d: match=%b cnt=%0d, expected match=%b cnt=%0d",
                   nm, i, match, match_cnt, m_match, m_cnt);
        end
      end
      step(1'b1, bits[i] == "1", i == abort_at, 1'b0, 1'b0, 1'b0, 3'($urandom), 0, 0);
      n_tests++;
      if (match !== m_match || match_cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL %s bit%0d: match=%b cnt=%0d, expected match=%b cnt=%0d",
                 nm, i, match, match_cnt, m_match, m_cnt);
      end
    end
    n_tests++;
    if (busy !== (m_st == 1) || done !== (m_st >= 2) || timed_out !== (m_st == 3) ||
        dbg_state !== state_e'(m_st[1:0])) begin
      n_fail++;
      $display("FAIL %s status: busy=%b done=%b to=%b st=%0d, expected busy=%b done=%b to=%b st=%0d",
               nm, busy, done, timed_out, dbg_state, (m_st == 1), (m_st >= 2), (m_st == 3), m_st);
    end
  endtask

  // return to IDLE: ack a finished run, abort an armed one
  task automatic finish_run(input string nm);
    if (m_st >= 2)      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 0, 0);
    else if (m_st == 1) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b0, 0, 0);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 || match_cnt !== 8'(m_cnt) ||
        dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s finish: busy=%b done=%b to=%b cnt=%0d, expected 0 0 0 cnt=%0d",
               nm, busy, done, timed_out, match_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    string s = "10101";
    reset = 1'b1; cfg_we = 0; start = 0; abort = 0; ack = 0; x_valid = 0; x = 0;
    cfg_pattern = 0; target_cnt = 0; max_samples = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mdl_reset();
    n_tests++;
    if ({busy, match, match_cnt, done, timed_out} !== 12'd0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset: busy=%b match=%b cnt=%0d done=%b to=%b, expected all 0",
               busy, match, match_cnt, done, timed_out);
    end
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i] == "1", 1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), 0, 0);
      n_tests++;
      if (match !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stream%0d: match=%b busy=%b, expected 0 0", i, match, busy);
      end
    end
    run_stream("default_pat", 1'b0, 3'b000, 1, 0, "101", 0, -1);
    n_tests++;
    if (match_cnt !== 8'd1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL default_pat: cnt=%0d done=%b, expected cnt=1 done=1", match_cnt, done);
    end
    finish_run("default_pat");
  endtask

  task automatic test_target3();
    run_stream("target3", 1'b0, 3'b000, 3, 0, "1010101", 0, -1);
    n_tests++;
    if (OVL ? (match_cnt !== 8'd3 || done !== 1'b1) : (match_cnt !== 8'd2 || busy !== 1'b1)) begin
      n_fail++;
      $display("FAIL target3: cnt=%0d done=%b busy=%b, expected cnt=%0d", match_cnt, done, busy,
               OVL ? 3 : 2);
    end
    finish_run("target3");
  endtask

  task automatic test_target2();
    run_stream("target2", 1'b0, 3'b000, 2, 0, "10101101", 0, -1);
    n_tests++;
    if (match_cnt !== 8'd2 || done !== 1'b1 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL target2: cnt=%0d done=%b to=%b, expected 2 1 0", match_cnt, done, timed_out);
    end
    finish_run("target2");
  endtask

  task automatic test_timeout();
    run_stream("timeout", 1'b1, 3'b110, 1, 4, "0000", 0, -1);
    n_tests++;
    if (timed_out !== 1'b1 || done !== 1'b1 || match_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout: to=%b done=%b cnt=%0d, expected 1 1 0", timed_out, done, match_cnt);
    end
    finish_run("timeout");
    run_stream("simul", 1'b0, 3'b000, 1, 3, "110", 0, -1);
    n_tests++;
    if (timed_out !== 1'b0 || done !== 1'b1 || match_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL simul: to=%b done=%b cnt=%0d, expected 0 1 1", timed_out, done, match_cnt);
    end
    finish_run("simul");
  endtask

  task automatic test_gaps();
    run_stream("gaps", 1'b1, 3'b101, 4, 0, "101", 2, -1);
    n_tests++;
    if (match_cnt !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps: cnt=%0d busy=%b, expected 1 1", match_cnt, busy);
    end
    finish_run("gaps");
  endtask

  task automatic test_abort();
    run_stream("abort", 1'b0, 3'b000, 5, 0, "101101", 0, 5);
    n_tests++;
    if (match !== 1'b0 || match_cnt !== 8'd1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: match=%b cnt=%0d busy=%b done=%b, expected 0 1 0 0",
               match, match_cnt, busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    run_stream("pre_reset", 1'b1, 3'b011, 5, 0, "0110", 0, -1);
    reset = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; x_valid = 1'b0;
    mdl_reset();
    n_tests++;
    if ({busy, match, match_cnt, done, timed_out} !== 12'd0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b match=%b cnt=%0d done=%b to=%b, expected all 0",
               busy, match, match_cnt, done, timed_out);
    end
  endtask

  task automatic test_target_zero();
    run_stream("target0", 1'b0, 3'b000, 0, 0, "101", 0, -1);
    n_tests++;
    if (done !== 1'b1 || match_cnt !== 8'd0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL target0: done=%b cnt=%0d to=%b, expected 1 0 0", done, match_cnt, timed_out);
    end
    finish_run("target0");
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 3'($urandom), $urandom_range(0, 4),
           ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0);
      for (int c = 0; c < 40 && m_st == 1; c++) begin
        step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0, 1'b0, 1'b0,
             1'($urandom), 3'($urandom), 0, 0);
        n_tests++;
        if (match !== m_match || match_cnt !== 8'(m_cnt) || dbg_state !== state_e'(m_st[1:0])) begin
          n_fail++;
          $display("FAIL rand%0d c%0d: match=%b cnt=%0d st=%0d, expected match=%b cnt=%0d st=%0d",
                   r, c, match, match_cnt, dbg_state, m_match, m_cnt, m_st);
        end
      end
      for (int c = 0; c < 3; c++) begin
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, m_st != 0 && 1'($urandom),
             1'($urandom), 3'($urandom), 3, 0);
        n_tests++;
        if (match !== m_match || match_cnt !== 8'(m_cnt) || done !== (m_st >= 2) ||
            timed_out !== (m_st == 3)) begin
          n_fail++;
          $display("FAIL rand%0d hold%0d: match=%b cnt=%0d done=%b to=%b, expected %b %0d %b %b",
                   r, c, match, match_cnt, done, timed_out, m_match, m_cnt, (m_st >= 2), (m_st == 3));
        end
      end
      finish_run("rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_target3();
    test_target2();
    test_timeout();
    test_gaps();
    test_abort();
    test_reset_midrun();
    test_target_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
